rx_byte_fifo: RTL and testbench
===============================

# rx_byte_fifo

Receive-side byte buffer between the UART receiver and the command interface. It captures each byte the receiver delivers on a `rx_done` rising edge, stores up to `DEPTH` bytes, and presents them first-word-fall-through to the interface, which pops them with a one-cycle `rd_en` strobe. This decouples command parsing from the serial line, so back-to-back frames arriving while the interface waits on `tx_done` are not lost.

## Interface
- `DATA_W`, 8: byte width; must match the receiver's `d_out`.
- `DEPTH`, 16: entries; power of two, minimum 2.
- `clk`  input  1  system clock, shared with the baud generator.
- `reset`  input  1  asynchronous, active-low reset.
- `d_in`  input  DATA_W  byte from the receiver; valid while `rx_done` is high.
- `rx_done`  input  1  receiver done level; may stay high for multiple clocks.
- `rd_en`  input  1  pop strobe from the interface.
- `d_out`  output  DATA_W  head entry; valid when `empty`=0.
- `empty`  output  1  no entries stored.
- `full`  output  1  `DEPTH` entries stored.
- `count`  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `overrun`  output  1  sticky: a byte was dropped because the FIFO was full.
- `clr_ovr`  input  1  clears `overrun`.

## Operation
- Edge detect: `rx_done_q` is `rx_done` registered. `push` = `rx_done & ~rx_done_q`, so there is exactly one push per receiver frame regardless of how long `rx_done` stays high.
- `pop` = `rd_en & ~empty`. A `rd_en` while empty is ignored; pointers and `count` do not move.
- Storage: `DEPTH`×`DATA_W` register array with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`.
- Push while not full: write `d_in` to `mem[wp]`, increment `wp` and `count`.
- Push while full with no pop: the byte is dropped, the pointers hold, and `overrun` is set.
- Push and pop in the same cycle:
  - Both are accepted and `count` is unchanged, including when full.
  - When empty, pop is invalid, so only the push is taken.
- `d_out` = `mem[rp]`, combinational from registers. Its value when `empty`=1 is don't-care but must not be X after reset: the memory resets to 0.
- `overrun` set/clear priority: a set in the same cycle as `clr_ovr` wins.

## Timing
- Reset state (async assert, sync-released domain): `wp`=`rp`=0, `count`=0, `empty`=1, `full`=0, `overrun`=0, `rx_done_q`=0, memory=0.
- Latency: with `rx_done` rising at edge N, push occurs at edge N+1, and `empty`=0 with `d_out`=byte after edge N+1.
- Pop at edge M: `d_out` shows the next entry after edge M.
- `empty`, `full` and `count` are registered or derived from registered state; no combinational path runs from `rd_en` to them.
- If `rx_done` is high when reset deasserts, `rx_done_q` starts at 0 and that frame is captured once.
- Reset mid-operation discards all contents immediately.

## Configuration
- `RX_FIFO_OVERRUN_EN` defined: sticky `overrun` flag with `clr_ovr`, as above.
- `RX_FIFO_OVERRUN_EN` undefined: `overrun` is tied to 0 and `clr_ovr` is ignored. Full-FIFO pushes are still dropped silently and the pointers still hold.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W`=8.
  - `RX_FIFO_DEPTH`=16.
  - Typedef `uart_byte_t`.
- Natural sub-module: `rising_edge_det`, a 1-bit registered edge detector with the same clock and reset. The rest of the design stays in one module.

## Test plan
- Single byte: after reset, pulse `rx_done` high 3 clocks with `d_in`=0xA5 → exactly one entry, `count`=1, `d_out`=0xA5 one cycle after the edge; `rd_en` pulse → `empty`=1, `count`=0.
- Fill and wrap: push 0x00..0x0F (16) → `full`=1; push 0x10 → dropped, `overrun`=1 (macro on); pop all → 0x00..0x0F in order. Then push and pop 20 more bytes to exercise pointer wrap, with order preserved.
- Simultaneous push/pop when full: `count`=16, push 0x55 and pop in the same cycle → `count`=16, oldest byte removed, 0x55 at tail.
- Pop when empty: `rd_en`=1 for 4 cycles with no data → `count`=0, `empty`=1, pointers unchanged; the next push reads back correctly.
- Overrun clear race: `clr_ovr` in the same cycle as a full-FIFO push → `overrun` stays 1; `clr_ovr` alone → 0. With the macro undefined → `overrun` is 0 throughout.
- Async reset mid-fill: 5 entries stored, assert `reset`=0 between clock edges → outputs go to reset values immediately; after release the FIFO is empty and the next byte captures correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, receive FIFO depth and the byte type.
package uart_pkg;

   localparam int UART_DATA_W   = 8;
   localparam int RX_FIFO_DEPTH = 16;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/rising_edge_det.sv
// One-bit registered rising-edge detector; pulse is high for the first cycle sig is seen high.
module rising_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic pulse
);

   logic sig_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig;
      end
   end

   assign pulse = sig & ~sig_q;

endmodule

// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO (first-word-fall-through) between the UART receiver and the command interface.
// Define RX_FIFO_OVERRUN_EN to get the sticky overrun flag with clr_ovr; otherwise overrun reads 0.
module rx_byte_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = RX_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        d_in,
   input  logic                     rx_done,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        d_out,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overrun,
   input  logic                     clr_ovr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wp;
   logic [PTR_W-1:0]  rp;
   logic              push;
   logic              pop;
   logic              wr_ok;

   rising_edge_det u_rx_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (rx_done),
      .pulse (push)
   );

   assign pop   = rd_en & ~empty;
   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign wr_ok = push & (~full | pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[wp] <= d_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_ok) begin
            wp <= wp + PTR_W'(1);
         end
         if (pop) begin
            rp <= rp + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else begin
         case ({wr_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));
   assign d_out = mem[rp];

`ifdef RX_FIFO_OVERRUN_EN
   logic ovr_set;

   assign ovr_set = push & full & ~pop;

   // A drop in the same cycle as clr_ovr keeps the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun <= 1'b0;
      end else if (ovr_set) begin
         overrun <= 1'b1;
      end else if (clr_ovr) begin
         overrun <= 1'b0;
      end
   end
`else
   logic unused_clr_ovr;

   assign unused_clr_ovr = clr_ovr;
   assign overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed scoreboard bench for rx_byte_fifo; expected overrun follows RX_FIFO_OVERRUN_EN.
module tb_rx_byte_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] d_in = '0;
   logic          rx_done = 1'b0;
   logic          rd_en = 1'b0;
   logic          clr_ovr = 1'b0;
   logic [DW-1:0] d_out;
   logic          empty;
   logic          full;
   logic [4:0]    count;
   logic          overrun;

   int            n_chk = 0;
   int            n_fail = 0;
   logic [DW-1:0] exp_q [$];
   bit            ovr_m = 1'b0;
   bit            rx_q_m = 1'b0;

   rx_byte_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .d_in    (d_in),
      .rx_done (rx_done),
      .rd_en   (rd_en),
      .d_out   (d_out),
      .empty   (empty),
      .full    (full),
      .count   (count),
      .overrun (overrun),
      .clr_ovr (clr_ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic bit exp_ovr();
`ifdef RX_FIFO_OVERRUN_EN
      return ovr_m;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".count"},   32'(count),   32'(exp_q.size()));
      chk({tag, ".empty"},   32'(empty),   32'(exp_q.size() == 0));
      chk({tag, ".full"},    32'(full),    32'(exp_q.size() == DEPTH));
      chk({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr()));
      if (exp_q.size() > 0) begin
         chk({tag, ".d_out"}, 32'(d_out), 32'(exp_q[0]));
      end
   endtask

   // Drive one clock of inputs, advance the scoreboard, then check at the falling edge.
   task automatic cycle(input string tag, input bit rx, input bit rd, input bit clr, input logic [DW-1:0] b);
      bit push_m, pop_m, set_m;
      int sz;
      d_in    = b;
      rx_done = rx;
      rd_en   = rd;
      clr_ovr = clr;
      @(negedge clk);
      sz     = exp_q.size();
      push_m = rx & ~rx_q_m;
      rx_q_m = rx;
      pop_m  = rd && (sz > 0);
      set_m  = push_m && (sz == DEPTH) && !pop_m;
      if (pop_m) void'(exp_q.pop_front());
      if (push_m && (sz < DEPTH || pop_m)) exp_q.push_back(b);
      if (set_m) ovr_m = 1'b1;
      else if (clr) ovr_m = 1'b0;
      check_all(tag);
   endtask

   task automatic push_byte(input string tag, input logic [DW-1:0] b);
      cycle(tag, 1'b1, 1'b0, 1'b0, b);
      cycle(tag, 1'b0, 1'b0, 1'b0, b);
   endtask

   task automatic pop_byte(input string tag);
      cycle(tag, 1'b0, 1'b1, 1'b0, '0);
   endtask

   initial begin
      #12;
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.empty", 32'(empty), 32'd1);
      chk("rst.full",  32'(full),  32'd0);
      chk("rst.ovr",   32'(overrun), 32'd0);
      chk("rst.d_out", 32'(d_out), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // single byte, rx_done held for three clocks
      cycle("single", 1'b1, 1'b0, 1'b0, 8'hA5);
      chk("single.first_edge", 32'(d_out), 32'hA5);
      cycle("single", 1'b1, 1'b0, 1'b0, 8'hA5);
      cycle("single", 1'b1, 1'b0, 1'b0, 8'hA5);
      cycle("single", 1'b0, 1'b0, 1'b0, 8'h00);
      chk("single.one_entry", 32'(count), 32'd1);
      pop_byte("single_pop");
      chk("single.empty_after_pop", 32'(empty), 32'd1);

      // pop while empty
      for (int i = 0; i < 4; i++) pop_byte("pop_empty");
      push_byte("after_empty", 8'h3E);
      pop_byte("after_empty_pop");

      // fill, overflow, drain in order
      for (int i = 0; i < DEPTH; i++) push_byte("fill", 8'(i));
      chk("fill.full", 32'(full), 32'd1);
      push_byte("overflow", 8'h10);
      chk("overflow.count", 32'(count), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain.order", 32'(d_out), 32'(i));
         pop_byte("drain");
      end

      // pointer wrap with interleaved push/pop
      cycle("clr", 1'b0, 1'b0, 1'b1, '0);
      for (int i = 0; i < 20; i++) begin
         push_byte("wrap_push", 8'(8'h20 + i));
         if (exp_q.size() >= 4) pop_byte("wrap_pop");
      end
      while (exp_q.size() > 0) pop_byte("wrap_drain");

      // simultaneous push and pop while full
      for (int i = 0; i < DEPTH; i++) push_byte("fill2", 8'(8'h40 + i));
      cycle("pp_full", 1'b1, 1'b1, 1'b0, 8'h55);
      chk("pp_full.count", 32'(count), 32'd16);
      chk("pp_full.head", 32'(d_out), 32'h41);
      cycle("pp_full", 1'b0, 1'b0, 1'b0, '0);

      // clear racing a dropped push, then a plain clear
      cycle("race", 1'b1, 1'b0, 1'b1, 8'h77);
`ifdef RX_FIFO_OVERRUN_EN
      chk("race.ovr_kept", 32'(overrun), 32'd1);
`else
      chk("race.ovr_off", 32'(overrun), 32'd0);
`endif
      cycle("race", 1'b0, 1'b0, 1'b0, '0);
      cycle("clr_alone", 1'b0, 1'b0, 1'b1, '0);
      chk("clr_alone.ovr", 32'(overrun), 32'd0);
      for (int i = 0; i < DEPTH - 1; i++) pop_byte("drain2");
      chk("drain2.tail", 32'(d_out), 32'h55);
      pop_byte("drain2");

      // async reset mid-fill, rx_done high across release
      for (int i = 0; i < 5; i++) push_byte("prefill", 8'(8'h60 + i));
      #2 reset = 1'b0;
      #1;
      chk("arst.count", 32'(count), 32'd0);
      chk("arst.empty", 32'(empty), 32'd1);
      chk("arst.full",  32'(full),  32'd0);
      chk("arst.d_out", 32'(d_out), 32'd0);
      chk("arst.ovr",   32'(overrun), 32'd0);
      d_in    = 8'h3C;
      rx_done = 1'b1;
      @(negedge clk);
      exp_q.delete();
      ovr_m  = 1'b0;
      rx_q_m = 1'b0;
      reset  = 1'b1;
      cycle("post_rst", 1'b1, 1'b0, 1'b0, 8'h3C);
      cycle("post_rst", 1'b1, 1'b0, 1'b0, 8'h3C);
      cycle("post_rst", 1'b0, 1'b0, 1'b0, 8'h00);
      chk("post_rst.once", 32'(count), 32'd1);
      chk("post_rst.byte", 32'(d_out), 32'h3C);
      push_byte("post_rst_next", 8'hC3);
      pop_byte("post_rst_pop");
      chk("post_rst.next", 32'(d_out), 32'hC3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
